coherence_coff_pipe: RTL and testbench

Fully pipelined, parametrised coherence-factor (CF) engine for N_CH receive channels. It computes CF = |Σs_i|² / (N_CH·Σs_i²) per sample and quantises it to COFF_W bits. An optional moving average over 2^AVG_LOG2 valid samples runs within each scan line. The block sits after beamforming delay alignment and before the CF weighting multiplier. It accepts one sample vector per clock, with bubbles allowed via `in_valid`.

---
 rtl/coherence_pkg.sv | 17 +
 rtl/coherence_div_stage.sv | 44 ++++
 rtl/coherence_coff_pipe.sv | 170 +++++++++++++++++
 tb/tb_coherence_coff_pipe.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/coherence_pkg.sv
// Shared constants and helpers for the coherence-factor pipeline.
package coherence_pkg;
    localparam int FMT_OFFSET = 0;
    localparam int FMT_TWOS   = 1;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    // Input-to-output latency: convert, square, tree, products, divide, saturate, average.
    function automatic int coff_lat(input int n_ch, input int coff_w);
        return 6 + clog2(n_ch) + coff_w;
    endfunction
endpackage

// File: rtl/coherence_div_stage.sv
// One registered restoring-division step; resolves quotient bit BIT.
module coherence_div_stage
    import coherence_pkg::*;
#(
    parameter int RW  = 31,
    parameter int QW  = 9,
    parameter int BIT = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_vld,
    input  logic          in_ls,
    input  logic [RW-1:0] in_rem,
    input  logic [RW-1:0] in_den,
    input  logic [QW-1:0] in_q,
    output logic          out_vld,
    output logic          out_ls,
    output logic [RW-1:0] out_rem,
    output logic [RW-1:0] out_den,
    output logic [QW-1:0] out_q
);
    logic          ge;
    logic [RW-1:0] diff;

    assign ge   = in_rem >= in_den;
    assign diff = ge ? in_rem - in_den : in_rem;

    // Remainder stays below DEN after subtraction, so the left shift cannot overflow.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_vld <= 1'b0;
            out_ls  <= 1'b0;
            out_rem <= '0;
            out_den <= '0;
            out_q   <= '0;
        end else begin
            out_vld <= in_vld;
            out_ls  <= in_ls;
            out_rem <= diff << 1;
            out_den <= in_den;
            out_q   <= in_q | (QW'(ge) << BIT);
        end
    end
endmodule

// File: rtl/coherence_coff_pipe.sv
// Pipelined coherence factor |sum s|^2 / (N*sum s^2), quantised, with per-line moving average.
module coherence_coff_pipe
    import coherence_pkg::*;
#(
    parameter int N_CH     = 8,
    parameter int DATA_W   = 12,
    parameter int COFF_W   = 8,
    parameter int AVG_LOG2 = 4,
    parameter int IN_FMT   = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic                     line_start,
    input  logic [N_CH*DATA_W-1:0]   data_in,
    output logic                     coff_valid,
    output logic [COFF_W-1:0]        coff
);
    localparam int L    = clog2(N_CH);
    localparam int SW   = DATA_W + L;
    localparam int QTW  = 2*DATA_W + L;
    localparam int PW   = 2*SW;
    localparam int RW   = PW + 1;
    localparam int PRE  = 3 + L;
    localparam int NDIV = COFF_W + 1;

    logic [PRE:1]             vld_pipe, ls_pipe;
    logic signed [DATA_W-1:0] s_cv   [N_CH];
    logic signed [SW-1:0]     s_node [1:2*N_CH-1];
    logic [QTW-1:0]           q_node [1:2*N_CH-1];
    logic signed [PW-1:0]     s_sq;
    logic [PW-1:0]            num_r, den_r;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_pipe <= '0;
            ls_pipe  <= '0;
        end else begin
            vld_pipe <= {vld_pipe[PRE-1:1], in_valid};
            ls_pipe  <= {ls_pipe[PRE-1:1], in_valid & line_start};
        end
    end

    // Convert, then square into the tree leaves (heap layout: leaves at N_CH..2*N_CH-1).
    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        logic [DATA_W-1:0]          raw;
        logic signed [2*DATA_W-1:0] sq;
        assign raw = data_in[k*DATA_W +: DATA_W];
        assign sq  = s_cv[k] * s_cv[k];
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                s_cv[k]          <= '0;
                s_node[N_CH+k]   <= '0;
                q_node[N_CH+k]   <= '0;
            end else begin
                s_cv[k]          <= (IN_FMT == FMT_OFFSET) ? {~raw[DATA_W-1], raw[DATA_W-2:0]} : raw;
                s_node[N_CH+k]   <= SW'(s_cv[k]);
                q_node[N_CH+k]   <= QTW'($unsigned(sq));
            end
        end
    end

    for (genvar i = 1; i < N_CH; i++) begin : g_node
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                s_node[i] <= '0;
                q_node[i] <= '0;
            end else begin
                s_node[i] <= s_node[2*i] + s_node[2*i+1];
                q_node[i] <= q_node[2*i] + q_node[2*i+1];
            end
        end
    end

    assign s_sq = s_node[1] * s_node[1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            num_r <= '0;
            den_r <= '0;
        end else begin
            num_r <= $unsigned(s_sq);
            den_r <= {q_node[1], {L{1'b0}}};
        end
    end

    logic              dv_vld [NDIV+1];
    logic              dv_ls  [NDIV+1];
    logic [RW-1:0]     dv_rem [NDIV+1];
    logic [RW-1:0]     dv_den [NDIV+1];
    logic [COFF_W:0]   dv_q   [NDIV+1];

    assign dv_vld[0] = vld_pipe[PRE];
    assign dv_ls[0]  = ls_pipe[PRE];
    assign dv_rem[0] = {1'b0, num_r};
    assign dv_den[0] = {1'b0, den_r};
    assign dv_q[0]   = '0;

    for (genvar j = 0; j < NDIV; j++) begin : g_div
        coherence_div_stage #(.RW(RW), .QW(COFF_W+1), .BIT(COFF_W-j)) u_div (
            .clk     (clk),
            .rst     (rst),
            .in_vld  (dv_vld[j]),
            .in_ls   (dv_ls[j]),
            .in_rem  (dv_rem[j]),
            .in_den  (dv_den[j]),
            .in_q    (dv_q[j]),
            .out_vld (dv_vld[j+1]),
            .out_ls  (dv_ls[j+1]),
            .out_rem (dv_rem[j+1]),
            .out_den (dv_den[j+1]),
            .out_q   (dv_q[j+1])
        );
    end

    logic              sat_vld, sat_ls;
    logic [COFF_W-1:0] sat_q;

    // All-zero input gives DEN = 0, which the divider would read as all ones.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sat_vld <= 1'b0;
            sat_ls  <= 1'b0;
            sat_q   <= '0;
        end else begin
            sat_vld <= dv_vld[NDIV];
            sat_ls  <= dv_ls[NDIV];
            if (dv_den[NDIV] == '0)     sat_q <= '0;
            else if (dv_q[NDIV][COFF_W]) sat_q <= '1;
            else                         sat_q <= dv_q[NDIV][COFF_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) coff_valid <= 1'b0;
        else      coff_valid <= sat_vld;
    end

    if (AVG_LOG2 == 0) begin : g_noavg
        always_ff @(posedge clk or negedge rst) begin
            if (!rst)         coff <= '0;
            else if (sat_vld) coff <= sat_q;
        end
    end else begin : g_avg
        localparam int D  = 1 << AVG_LOG2;
        localparam int AW = COFF_W + AVG_LOG2;

        logic [COFF_W-1:0] hist [D];
        logic [AW-1:0]     acc, acc_base, acc_next;
        logic [COFF_W-1:0] oldest;

        // A line start treats the whole window as zero before adding the new sample.
        assign acc_base = sat_ls ? '0 : acc;
        assign oldest   = sat_ls ? '0 : hist[D-1];
        assign acc_next = acc_base + AW'(sat_q) - AW'(oldest);

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                acc  <= '0;
                coff <= '0;
                for (int i = 0; i < D; i++) hist[i] <= '0;
            end else if (sat_vld) begin
                acc     <= acc_next;
                coff    <= COFF_W'(acc_next >> AVG_LOG2);
                hist[0] <= sat_q;
                for (int i = 1; i < D; i++) hist[i] <= sat_ls ? '0 : hist[i-1];
            end
        end
    end
endmodule

// File: tb/tb_coherence_coff_pipe.sv
// Scoreboard bench: three configurations driven by one channel-value stream.
module tb_coherence_coff_pipe;
    localparam int N   = 8;
    localparam int DW  = 12;
    localparam int CW  = 8;
    localparam int LAT = 17;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0;
    logic          line_start = 1'b0;
    logic [N*DW-1:0] d_twos = '0;
    logic [N*DW-1:0] d_off  = '0;
    logic          va, vb, vc;
    logic [CW-1:0] ca, cb, cc;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int ch [N];

    typedef struct {
        int cyc;
        int a;
        int c;
    } exp_t;
    exp_t sb[$];
    int   win[$];
    int   la = 0, lc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // a: two's complement, no averaging; b: offset binary, no averaging; c: two's complement, 16-sample average
    coherence_coff_pipe #(.N_CH(N), .DATA_W(DW), .COFF_W(CW), .AVG_LOG2(0), .IN_FMT(1)) u_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .line_start(line_start),
        .data_in(d_twos), .coff_valid(va), .coff(ca));
    coherence_coff_pipe #(.N_CH(N), .DATA_W(DW), .COFF_W(CW), .AVG_LOG2(0), .IN_FMT(0)) u_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .line_start(line_start),
        .data_in(d_off), .coff_valid(vb), .coff(cb));
    coherence_coff_pipe #(.N_CH(N), .DATA_W(DW), .COFF_W(CW), .AVG_LOG2(4), .IN_FMT(1)) u_c (
        .clk(clk), .rst(rst), .in_valid(in_valid), .line_start(line_start),
        .data_in(d_twos), .coff_valid(vc), .coff(cc));

    task automatic chk(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int cf_q();
        longint s, q, num, den, r;
        s = 0;
        q = 0;
        for (int k = 0; k < N; k++) begin
            s += ch[k];
            q += ch[k] * ch[k];
        end
        if (q == 0) return 0;
        num = s * s;
        den = q * N;
        r   = (num * 256) / den;
        return (r > 255) ? 255 : int'(r);
    endfunction

    task automatic set_all(input int v);
        for (int k = 0; k < N; k++) ch[k] = v;
    endtask

    task automatic rand_ch();
        for (int k = 0; k < N; k++) ch[k] = int'($urandom_range(0, 4095)) - 2048;
    endtask

    task automatic drive(input bit v, input bit ls);
        int q, sum, t;
        @(negedge clk);
        in_valid   = v;
        line_start = ls;
        for (int k = 0; k < N; k++) begin
            t = ch[k];
            d_twos[k*DW +: DW] = t[DW-1:0];
            t = ch[k] + 2048;
            d_off[k*DW +: DW] = t[DW-1:0];
        end
        if (v) begin
            q = cf_q();
            if (ls) win.delete();
            win.push_back(q);
            if (win.size() > 16) void'(win.pop_front());
            sum = 0;
            foreach (win[i]) sum += win[i];
            sb.push_back('{cyc + LAT, q, sum / 16});
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            la = 0;
            lc = 0;
        end else if (va | vb | vc) begin
            chk("sb_pending", sb.size() > 0, 1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("latency", cyc, e.cyc);
                chk("valid_a", va, 1);
                chk("valid_b", vb, 1);
                chk("valid_c", vc, 1);
                chk("coff_a", ca, e.a);
                chk("coff_b", cb, e.a);
                chk("coff_c", cc, e.c);
                la = e.a;
                lc = e.c;
            end
        end else begin
            chk("hold_a", ca, la);
            chk("hold_b", cb, la);
            chk("hold_c", cc, lc);
        end
    end

    initial begin
        set_all(0);
        repeat (2) @(negedge clk);
        #1;
        chk("rst_valid_a", va, 0);
        chk("rst_coff_a", ca, 0);
        chk("rst_valid_c", vc, 0);
        chk("rst_coff_c", cc, 0);
        #1 rst = 1'b1;

        set_all(100);               drive(1, 1);
        repeat (3) drive(0, 0);
        for (int k = 0; k < N; k++) ch[k] = (k % 2) ? -100 : 100;
        drive(1, 0);
        set_all(0);                 drive(1, 0);
        ch[3] = -700;               drive(1, 0);

        // ramp of single-channel samples, then a restart
        drive(1, 1);
        repeat (19) drive(1, 0);
        drive(1, 1);
        repeat (4) drive(1, 0);
        drive(0, 1);
        repeat (3) drive(1, 0);

        // bubbles on full-coherence input
        set_all(100);
        drive(1, 1);
        repeat (60) drive($urandom_range(0, 2) != 0, 0);

        repeat (6) begin rand_ch(); drive(1, 1); end
        repeat (200) begin
            rand_ch();
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
        end

        // reset with samples in flight
        repeat (8) begin rand_ch(); drive(1, 0); end
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_valid_a", va, 0);
        chk("mid_rst_coff_a", ca, 0);
        chk("mid_rst_valid_c", vc, 0);
        chk("mid_rst_coff_c", cc, 0);
        sb.delete();
        win.delete();
        in_valid   = 1'b0;
        line_start = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        ch[0] = 300; ch[1] = 0; ch[2] = 0; ch[3] = 0;
        ch[4] = 0;   ch[5] = 0; ch[6] = 0; ch[7] = 0;
        repeat (5) drive(1, 0);
        repeat (15) begin rand_ch(); drive(1, 0); end

        repeat (LAT + 4) begin rand_ch(); drive(0, 0); end
        chk("sb_drain", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
